// File: rtl/pkt_slot_buffer_pkg.sv
// Shared types and width helpers for the multi-slot packet buffer.
package pkt_slot_buffer_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RUN
  } rd_state_t;

  // Address width for n locations; never collapses to zero bits.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the count 0..n inclusive.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pkt_slot_buffer_if.sv
// Write/read port bundle of the packet slot buffer, plus FSM state for observation.
interface pkt_slot_buffer_if
  import pkt_slot_buffer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SLOTS      = 16,
  parameter int SLOT_BYTES = 1024
);
  localparam int SLOT_AW = addr_w(SLOTS);
  localparam int LEN_W   = count_w(SLOT_BYTES);

  // Handshakes: a write beat transfers when wr_valid && wr_ready, a read beat
  // when rd_valid && rd_ready; the source holds its beat stable until then.
  logic                wr_start;
  logic [SLOT_AW-1:0]  wr_slot;
  logic                wr_valid;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_last;
  logic                wr_ready;
  logic                wr_err;

  logic                rd_start;
  logic [SLOT_AW-1:0]  rd_slot;
  logic                rd_release;
  logic                rd_ready;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_last;
  logic [LEN_W-1:0]    rd_len;
  logic                rd_err;

  logic [SLOTS-1:0]    slot_full;
  wr_state_t           wr_state;
  rd_state_t           rd_state;

  modport master (
    output wr_start, wr_slot, wr_valid, wr_data, wr_last,
    output rd_start, rd_slot, rd_release, rd_ready,
    input  wr_ready, wr_err,
    input  rd_valid, rd_data, rd_last, rd_len, rd_err,
    input  slot_full, wr_state, rd_state
  );

  modport slave (
    input  wr_start, wr_slot, wr_valid, wr_data, wr_last,
    input  rd_start, rd_slot, rd_release, rd_ready,
    output wr_ready, wr_err,
    output rd_valid, rd_data, rd_last, rd_len, rd_err,
    output slot_full, wr_state, rd_state
  );

endinterface

// File: rtl/pkt_slot_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module sdp_ram
  import pkt_slot_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16384
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_w(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [addr_w(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_slot_buffer.sv
// Multi-slot packet store: byte-serial fill of fixed-size slots, streamed read-out
// through a 2-entry skid FIFO, with per-slot length and occupancy tracking.
module pkt_slot_buffer
  import pkt_slot_buffer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SLOTS      = 16,
  parameter int SLOT_BYTES = 1024
) (
  input logic               clk,
  input logic               rst,
  pkt_slot_buffer_if.slave  bus
);

  localparam int SLOT_AW = addr_w(SLOTS);
  localparam int BYTE_AW = addr_w(SLOT_BYTES);
  localparam int LEN_W   = count_w(SLOT_BYTES);
  localparam int DEPTH   = SLOTS * SLOT_BYTES;
  localparam int RAM_AW  = SLOT_AW + BYTE_AW;

  generate
    if (!is_pow2(SLOT_BYTES)) begin : g_bad_slot_bytes
      $error("pkt_slot_buffer: SLOT_BYTES must be a power of two");
    end
  endgenerate

  logic [SLOTS-1:0] slot_full;
  logic [LEN_W-1:0] len_tbl [SLOTS];

  // ---------------- write side ----------------
  wr_state_t          wr_state, wr_state_nx;
  logic [SLOT_AW-1:0] wr_slot_q;
  logic [BYTE_AW-1:0] wr_ptr;
  logic               wr_err_q;
  logic               wr_beat, wr_at_end;
  logic               wr_accept, wr_reject, wr_commit, wr_overflow, ram_we;

  assign bus.wr_ready = (wr_state != W_IDLE);
  assign wr_beat      = bus.wr_valid && bus.wr_ready;
  assign wr_at_end    = (wr_ptr == BYTE_AW'(SLOT_BYTES - 1));

  always_comb begin
    wr_state_nx = wr_state;
    wr_accept   = 1'b0;
    wr_reject   = 1'b0;
    wr_commit   = 1'b0;
    wr_overflow = 1'b0;
    ram_we      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (bus.wr_start) begin
          if (!slot_full[bus.wr_slot]) begin
            wr_accept   = 1'b1;
            wr_state_nx = W_FILL;
          end else begin
            wr_reject   = 1'b1;
            wr_state_nx = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (wr_beat) begin
          // An overflowing beat may land in RAM; the slot is never marked full.
          ram_we = 1'b1;
          if (bus.wr_last) begin
            wr_commit   = 1'b1;
            wr_state_nx = W_IDLE;
          end else if (wr_at_end) begin
            wr_overflow = 1'b1;
            wr_state_nx = W_DROP;
          end
        end
      end
      W_DROP: begin
        if (wr_beat && bus.wr_last) wr_state_nx = W_IDLE;
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_slot_q <= '0;
      wr_ptr    <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      wr_err_q <= wr_reject || wr_overflow;
      if (wr_accept) begin
        wr_slot_q <= bus.wr_slot;
        wr_ptr    <= '0;
      end else if (wr_state == W_FILL && wr_beat) begin
        wr_ptr <= wr_ptr + BYTE_AW'(1);
      end
    end
  end

  assign bus.wr_err   = wr_err_q;
  assign bus.wr_state = wr_state;

  // ---------------- read side ----------------
  rd_state_t          rd_state, rd_state_nx;
  logic [SLOT_AW-1:0] rd_slot_q;
  logic               rd_rel_q;
  logic [LEN_W-1:0]   rd_len_q;
  logic [LEN_W-1:0]   rptr;
  logic               rd_err_q;
  logic               rd_accept, rd_reject, rd_done;
  logic               inflight, inflight_last;
  logic [DATA_W-1:0]  fifo_data [2];
  logic [1:0]         fifo_last;
  logic               fifo_head, fifo_tail;
  logic [1:0]         fifo_count, occ;
  logic               pop, run_issue, issue, issue_last;
  logic [LEN_W-1:0]   issue_idx, issue_len;
  logic [RAM_AW-1:0]  ram_raddr;
  logic [DATA_W-1:0]  ram_rdata;

  assign bus.rd_valid = (fifo_count != 2'd0);
  assign bus.rd_data  = fifo_data[fifo_head];
  assign bus.rd_last  = bus.rd_valid && fifo_last[fifo_head];
  assign pop          = bus.rd_valid && bus.rd_ready;
  assign rd_done      = pop && fifo_last[fifo_head];

  // A beat popped this cycle frees its entry in time for a read issued now,
  // which keeps one beat per cycle with only two skid entries.
  assign occ        = fifo_count + {1'b0, inflight};
  assign run_issue  = (rd_state == R_RUN) && (rptr < rd_len_q) && ((occ < 2'd2) || pop);
  assign issue      = rd_accept || run_issue;
  assign issue_idx  = rd_accept ? '0 : rptr;
  assign issue_len  = rd_accept ? len_tbl[bus.rd_slot] : rd_len_q;
  assign issue_last = (issue_idx == issue_len - LEN_W'(1));
  assign ram_raddr  = rd_accept ? {bus.rd_slot, BYTE_AW'(0)} : {rd_slot_q, rptr[BYTE_AW-1:0]};

  always_comb begin
    rd_state_nx = rd_state;
    rd_accept   = 1'b0;
    rd_reject   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (bus.rd_start) begin
          if (slot_full[bus.rd_slot]) begin
            rd_accept   = 1'b1;
            rd_state_nx = R_RUN;
          end else begin
            rd_reject = 1'b1;
          end
        end
      end
      R_RUN: begin
        if (rd_done) rd_state_nx = R_IDLE;
      end
      default: rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      rd_slot_q     <= '0;
      rd_rel_q      <= 1'b0;
      rd_len_q      <= '0;
      rptr          <= '0;
      rd_err_q      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      fifo_head     <= 1'b0;
      fifo_tail     <= 1'b0;
      fifo_count    <= '0;
    end else begin
      rd_state      <= rd_state_nx;
      rd_err_q      <= rd_reject;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (rd_accept) begin
        rd_slot_q <= bus.rd_slot;
        rd_rel_q  <= bus.rd_release;
        rd_len_q  <= len_tbl[bus.rd_slot];
        rptr      <= LEN_W'(1);
      end else if (run_issue) begin
        rptr <= rptr + LEN_W'(1);
      end
      if (inflight) begin
        fifo_data[fifo_tail] <= ram_rdata;
        fifo_last[fifo_tail] <= inflight_last;
        fifo_tail            <= ~fifo_tail;
      end
      if (pop) fifo_head <= ~fifo_head;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign bus.rd_err   = rd_err_q;
  assign bus.rd_len   = rd_len_q;
  assign bus.rd_state = rd_state;

  // ---------------- occupancy and lengths ----------------
  // Set (write commit) and clear (read release) never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full <= '0;
      for (int i = 0; i < SLOTS; i++) len_tbl[i] <= '0;
    end else begin
      if (wr_commit) begin
        slot_full[wr_slot_q] <= 1'b1;
        len_tbl[wr_slot_q]   <= LEN_W'(wr_ptr) + LEN_W'(1);
      end
      if (rd_done && rd_rel_q) slot_full[rd_slot_q] <= 1'b0;
    end
  end

  assign bus.slot_full = slot_full;

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_slot_q, wr_ptr}),
    .wdata (bus.wr_data),
    .re    (issue),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pkt_slot_buffer.sv
// Directed bench for pkt_slot_buffer with 16-byte slots.
module tb_pkt_slot_buffer;
  import pkt_slot_buffer_pkg::*;

  localparam int DATA_W     = 8;
  localparam int SLOTS      = 16;
  localparam int SLOT_BYTES = 16;
  localparam int BUDGET     = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_slot_buffer_if #(.DATA_W(DATA_W), .SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES)) bus ();

  pkt_slot_buffer #(.DATA_W(DATA_W), .SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rx_q[$];
  int rx_last_idx, n_last, first_valid, got_len, hold_viol;
  bit timed_out;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_start   = 1'b0;
    bus.wr_slot    = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_last    = 1'b0;
    bus.rd_start   = 1'b0;
    bus.rd_slot    = '0;
    bus.rd_release = 1'b0;
    bus.rd_ready   = 1'b0;
  endtask

  task automatic write_pkt(input logic [3:0] slot, input int n, input logic [7:0] base);
    bus.wr_start = 1'b1;
    bus.wr_slot  = slot;
    step();
    bus.wr_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 8'(i);
      bus.wr_last  = (i == n - 1);
      step();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  // Streams one slot out, recording accepted beats and any change while stalled.
  task automatic read_pkt(input logic [3:0] slot, input bit rel, input bit stall);
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    bit          done;
    rx_q.delete();
    rx_last_idx = -1;
    n_last      = 0;
    first_valid = -1;
    got_len     = -1;
    hold_viol   = 0;
    timed_out   = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_last   = 1'b0;
    done        = 1'b0;
    bus.rd_start   = 1'b1;
    bus.rd_slot    = slot;
    bus.rd_release = rel;
    bus.rd_ready   = 1'b0;
    step();
    bus.rd_start   = 1'b0;
    bus.rd_release = 1'b0;
    for (int c = 1; c < BUDGET && !done; c++) begin
      bus.rd_ready = stall ? (c % 3 == 1) : 1'b1;
      if (prev_stall && (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_data ||
                         bus.rd_last !== prev_last))
        hold_viol++;
      if (bus.rd_valid === 1'b1 && first_valid < 0) begin
        first_valid = c;
        got_len     = int'(bus.rd_len);
      end
      prev_stall = (bus.rd_valid === 1'b1) && !bus.rd_ready;
      prev_data  = bus.rd_data;
      prev_last  = bus.rd_last;
      if (bus.rd_valid === 1'b1 && bus.rd_ready) begin
        rx_q.push_back(bus.rd_data);
        if (bus.rd_last === 1'b1) begin
          n_last++;
          rx_last_idx = rx_q.size() - 1;
          done = 1'b1;
        end
      end
      step();
    end
    bus.rd_ready = 1'b0;
    if (!done) timed_out = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr got ready=%b err=%b want 0 0", bus.wr_ready, bus.wr_err);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd got valid=%b last=%b err=%b want 0 0 0",
               bus.rd_valid, bus.rd_last, bus.rd_err);
    end
    checks++;
    if (bus.rd_data !== 8'h00 || bus.rd_len !== '0) begin
      errors++;
      $display("FAIL reset_rd_bus got data=%h len=%0d want 00 0", bus.rd_data, bus.rd_len);
    end
    checks++;
    if (bus.slot_full !== 16'h0000) begin
      errors++;
      $display("FAIL reset_full got %h want 0000", bus.slot_full);
    end
  endtask

  task automatic test_basic();
    int bad;
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    write_pkt(4'd3, 5, 8'h11);
    checks++;
    if (bus.slot_full !== 16'h0008) begin
      errors++;
      $display("FAIL basic_full_set got %h want 0008", bus.slot_full);
    end
    read_pkt(4'd3, 1'b1, 1'b0);
    checks++;
    if (timed_out || first_valid != 2) begin
      errors++;
      $display("FAIL basic_latency got %0d want 2 (timeout=%0b)", first_valid, timed_out);
    end
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (rx_q.size() != exp_q.size() || bad != 0) begin
      errors++;
      $display("FAIL basic_data got n=%0d bad=%0d want n=5 bad=0", rx_q.size(), bad);
    end
    checks++;
    if (rx_last_idx != 4 || n_last != 1) begin
      errors++;
      $display("FAIL basic_last got idx=%0d n=%0d want 4 1", rx_last_idx, n_last);
    end
    checks++;
    if (got_len != 5) begin
      errors++;
      $display("FAIL basic_len got %0d want 5", got_len);
    end
    checks++;
    if (bus.slot_full !== 16'h0000) begin
      errors++;
      $display("FAIL basic_full_clear got %h want 0000", bus.slot_full);
    end
  endtask

  task automatic test_stall();
    int bad;
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    write_pkt(4'd5, 4, 8'hA0);
    read_pkt(4'd5, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (timed_out || rx_q.size() != 4 || bad != 0) begin
      errors++;
      $display("FAIL stall_data got n=%0d bad=%0d timeout=%0b want 4 0 0", rx_q.size(), bad, timed_out);
    end
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d changes want 0", hold_viol);
    end
    checks++;
    if (rx_last_idx != 3 || got_len != 4) begin
      errors++;
      $display("FAIL stall_last got idx=%0d len=%0d want 3 4", rx_last_idx, got_len);
    end
  endtask

  task automatic test_busy_slot();
    int bad, not_ready;
    exp_q = '{8'h31, 8'h32, 8'h33};
    write_pkt(4'd3, 3, 8'h31);
    bus.wr_start = 1'b1;
    bus.wr_slot  = 4'd3;
    step();
    bus.wr_start = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b1 || bus.wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_err got err=%b ready=%b want 1 1", bus.wr_err, bus.wr_ready);
    end
    not_ready = 0;
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hEE;
      bus.wr_last  = (i == 5);
      if (bus.wr_ready !== 1'b1) not_ready++;
      step();
      if (i == 0) begin
        checks++;
        if (bus.wr_err !== 1'b0) begin
          errors++;
          $display("FAIL busy_pulse got err=%b want 0", bus.wr_err);
        end
      end
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    checks++;
    if (not_ready != 0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_sink got stalls=%0d ready_after=%b want 0 0", not_ready, bus.wr_ready);
    end
    read_pkt(4'd3, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (timed_out || rx_q.size() != 3 || bad != 0 || got_len != 3) begin
      errors++;
      $display("FAIL busy_reread got n=%0d bad=%0d len=%0d want 3 0 3", rx_q.size(), bad, got_len);
    end
    checks++;
    if (bus.slot_full !== 16'h0008) begin
      errors++;
      $display("FAIL busy_keep got %h want 0008", bus.slot_full);
    end
  endtask

  task automatic test_overflow();
    int bad, err_seen;
    bus.wr_start = 1'b1;
    bus.wr_slot  = 4'd6;
    step();
    bus.wr_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(i);
      bus.wr_last  = (i == 16);
      step();
      if (i == 14) begin
        checks++;
        if (bus.wr_err !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got err=%b want 0", bus.wr_err);
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.wr_err !== 1'b1) begin
          errors++;
          $display("FAIL ovf_err got err=%b want 1", bus.wr_err);
        end
      end
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    checks++;
    if (bus.slot_full[6] !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty got full=%b ready=%b want 0 0", bus.slot_full[6], bus.wr_ready);
    end
    // Exactly one slot's worth with wr_last on the final byte is legal.
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    bus.wr_start = 1'b1;
    bus.wr_slot  = 4'd6;
    step();
    bus.wr_start = 1'b0;
    err_seen = 0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h40 + 8'(i);
      bus.wr_last  = (i == 15);
      step();
      if (bus.wr_err === 1'b1) err_seen++;
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    checks++;
    if (err_seen != 0 || bus.slot_full[6] !== 1'b1) begin
      errors++;
      $display("FAIL full_slot_write got errs=%0d full=%b want 0 1", err_seen, bus.slot_full[6]);
    end
    read_pkt(4'd6, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (timed_out || got_len != 16 || rx_q.size() != 16 || bad != 0 || rx_last_idx != 15) begin
      errors++;
      $display("FAIL full_slot_read got len=%0d n=%0d bad=%0d last=%0d want 16 16 0 15",
               got_len, rx_q.size(), bad, rx_last_idx);
    end
  endtask

  task automatic test_rd_err_and_reset();
    bus.rd_start = 1'b1;
    bus.rd_slot  = 4'd7;
    step();
    bus.rd_start = 1'b0;
    checks++;
    if (bus.rd_err !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rderr_pulse got err=%b valid=%b want 1 0", bus.rd_err, bus.rd_valid);
    end
    step();
    step();
    checks++;
    if (bus.rd_err !== 1'b0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rderr_after got err=%b valid=%b want 0 0", bus.rd_err, bus.rd_valid);
    end
    write_pkt(4'd7, 6, 8'h70);
    bus.rd_start   = 1'b1;
    bus.rd_slot    = 4'd7;
    bus.rd_release = 1'b0;
    step();
    bus.rd_start = 1'b0;
    step();
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h70 || bus.slot_full !== 16'h0088) begin
      errors++;
      $display("FAIL midread got valid=%b data=%h full=%h want 1 70 0088",
               bus.rd_valid, bus.rd_data, bus.slot_full);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_data !== 8'h00 ||
        bus.rd_len !== '0 || bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd got valid=%b last=%b data=%h len=%0d err=%b want 0 0 00 0 0",
               bus.rd_valid, bus.rd_last, bus.rd_data, bus.rd_len, bus.rd_err);
    end
    checks++;
    if (bus.slot_full !== 16'h0000 || bus.wr_ready !== 1'b0 || bus.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got full=%h wr_ready=%b wr_err=%b want 0000 0 0",
               bus.slot_full, bus.wr_ready, bus.wr_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_free_collision();
    bit seen;
    write_pkt(4'd2, 2, 8'h21);
    bus.rd_start   = 1'b1;
    bus.rd_slot    = 4'd2;
    bus.rd_release = 1'b1;
    step();
    bus.rd_start   = 1'b0;
    bus.rd_release = 1'b0;
    bus.rd_ready   = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (bus.rd_valid === 1'b1 && bus.rd_last === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!seen || bus.rd_data !== 8'h22) begin
      errors++;
      $display("FAIL coll_last got seen=%0b data=%h want 1 22", seen, bus.rd_data);
    end
    bus.wr_start = 1'b1;
    bus.wr_slot  = 4'd2;
    step();
    bus.wr_start = 1'b0;
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b1 || bus.slot_full[2] !== 1'b0) begin
      errors++;
      $display("FAIL coll_reject got err=%b full2=%b want 1 0", bus.wr_err, bus.slot_full[2]);
    end
    bus.wr_valid = 1'b1;
    bus.wr_last  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.wr_start = 1'b1;
    bus.wr_slot  = 4'd2;
    step();
    bus.wr_start = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b0 || bus.wr_ready !== 1'b1 || bus.wr_state !== W_FILL) begin
      errors++;
      $display("FAIL coll_retry got err=%b ready=%b state=%0d want 0 1 1",
               bus.wr_err, bus.wr_ready, bus.wr_state);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    bus.wr_last  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    read_pkt(4'd2, 1'b1, 1'b0);
    checks++;
    if (timed_out || rx_q.size() != 1 || got_len != 1 || rx_last_idx != 0 ||
        (rx_q.size() == 1 && rx_q[0] !== 8'h77)) begin
      errors++;
      $display("FAIL coll_readback got n=%0d len=%0d last=%0d want 1 1 0 data 77",
               rx_q.size(), got_len, rx_last_idx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic();
    test_stall();
    test_busy_slot();
    test_overflow();
    test_rd_err_and_reset();
    test_free_collision();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
